// File: rtl/nrf_spi_pkg.sv
// Shared constants for the nRF24L01 SPI responder: opcodes, register map,
// STATUS layout and the command FSM state type.
package nrf_spi_pkg;

  localparam logic [2:0] OP_R_REGISTER   = 3'b000;
  localparam logic [2:0] OP_W_REGISTER   = 3'b001;
  localparam logic [7:0] OP_R_RX_PAYLOAD = 8'h61;
  localparam logic [7:0] OP_W_TX_PAYLOAD = 8'hA0;
  localparam logic [7:0] OP_NOP          = 8'hFF;

  localparam logic [4:0] ADDR_CONFIG     = 5'h00;
  localparam logic [4:0] ADDR_EN_AA      = 5'h01;
  localparam logic [4:0] ADDR_EN_RXADDR  = 5'h02;
  localparam logic [4:0] ADDR_SETUP_AW   = 5'h03;
  localparam logic [4:0] ADDR_SETUP_RETR = 5'h04;
  localparam logic [4:0] ADDR_RF_CH      = 5'h05;
  localparam logic [4:0] ADDR_RF_SETUP   = 5'h06;
  localparam logic [4:0] ADDR_STATUS     = 5'h07;

  localparam logic [7:0] RST_CONFIG      = 8'h08;
  localparam logic [7:0] RST_EN_AA       = 8'h3F;
  localparam logic [7:0] RST_EN_RXADDR   = 8'h03;
  localparam logic [7:0] RST_SETUP_AW    = 8'h03;
  localparam logic [7:0] RST_SETUP_RETR  = 8'h03;
  localparam logic [7:0] RST_RF_CH       = 8'h02;
  localparam logic [7:0] RST_RF_SETUP    = 8'h0F;

  localparam int STATUS_RX_DR = 6;
  localparam int STATUS_TX_DS = 5;

  localparam logic [2:0] PAYLOAD_BYTES = 3'd4;

  typedef enum logic [1:0] {IDLE, CMD, DATA, IGNORE} state_e;

  function automatic logic [7:0] reg_reset_value(input logic [2:0] addr);
    case (addr)
      ADDR_CONFIG[2:0]:     return RST_CONFIG;
      ADDR_EN_AA[2:0]:      return RST_EN_AA;
      ADDR_EN_RXADDR[2:0]:  return RST_EN_RXADDR;
      ADDR_SETUP_AW[2:0]:   return RST_SETUP_AW;
      ADDR_SETUP_RETR[2:0]: return RST_SETUP_RETR;
      ADDR_RF_CH[2:0]:      return RST_RF_CH;
      ADDR_RF_SETUP[2:0]:   return RST_RF_SETUP;
      default:              return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin with registered rise/fall pulses.
module spi_sync_edge #(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;
  logic       rise_q;
  logic       fall_q;

  // sync_q[1] is the synchronized level, sync_q[2] its previous value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {3{INIT}};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], d_i};
      rise_q <= sync_q[1] & ~sync_q[2];
      fall_q <= ~sync_q[1] & sync_q[2];
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/nrf_spi_responder.sv
// nRF24L01 command-interface SPI slave model: oversampled mode-0 SPI, command
// decode, small register file with STATUS flags, and 4-byte RX/TX payload buffers.
module nrf_spi_responder
  import nrf_spi_pkg::*;
(
  input  logic        clk_10,
  input  logic        rst,
  input  logic        sck,
  input  logic        csn,
  input  logic        mosi,
  output logic        miso,
  input  logic [31:0] rx_payload_in,
  input  logic        rx_payload_load,
  input  logic        tx_done_in,
  output logic [31:0] tx_payload_out,
  output logic        tx_payload_valid,
  output logic [7:0]  config_out
);

  logic sck_rise, sck_fall, csn_rise, csn_fall;

  spi_sync_edge #(.INIT(1'b0)) u_sck_sync (
    .clk(clk_10), .rst(rst), .d_i(sck), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  // csn idles high, so its synchronizer resets high to avoid a false edge
  spi_sync_edge #(.INIT(1'b1)) u_csn_sync (
    .clk(clk_10), .rst(rst), .d_i(csn), .rise_o(csn_rise), .fall_o(csn_fall)
  );

  state_e      state_q, state_d;
  logic [1:0]  mosi_sync_q;
  logic [7:0]  sout_q;
  logic [6:0]  sin_q;
  logic [2:0]  bit_cnt_q;
  logic [2:0]  byte_cnt_q;
  logic [7:0]  cmd_q;
  logic [7:0]  regs_q [0:6];
  logic        rx_dr_q, tx_ds_q;
  logic [31:0] rx_buf_q, tx_buf_q, tx_out_q;
  logic        tx_valid_q;

  logic        mosi_s, active, last_bit;
  logic [7:0]  byte_in, status, rd_data, out_byte;
  logic [4:0]  cmd_addr;
  logic [1:0]  data_idx;
  logic        we, rx_clear, tx_fill, tx_commit, in_payload;

  assign mosi_s     = mosi_sync_q[1];
  assign active     = (state_q != IDLE);
  assign last_bit   = active && sck_rise && (bit_cnt_q == 3'd7);
  assign byte_in    = {sin_q, mosi_s};
  assign cmd_addr   = cmd_q[4:0];
  assign data_idx   = byte_cnt_q[1:0] - 2'd1;
  assign in_payload = (byte_cnt_q != 3'd0) && (byte_cnt_q <= PAYLOAD_BYTES);
  assign status     = {1'b0, rx_dr_q, tx_ds_q, 1'b0, (rx_dr_q ? 3'b000 : 3'b111), 1'b0};

  assign we        = (state_q == DATA) && last_bit && (byte_cnt_q == 3'd1) &&
                     (cmd_q[7:5] == OP_W_REGISTER);
  assign tx_fill   = (state_q == DATA) && last_bit && in_payload && (cmd_q == OP_W_TX_PAYLOAD);
  assign tx_commit = (state_q == DATA) && csn_rise && (byte_cnt_q > PAYLOAD_BYTES) &&
                     (cmd_q == OP_W_TX_PAYLOAD);
  assign rx_clear  = (state_q == DATA) && csn_rise && (byte_cnt_q > PAYLOAD_BYTES) &&
                     (cmd_q == OP_R_RX_PAYLOAD);

  always_comb begin
    rd_data = 8'h00;
    if (cmd_addr == ADDR_STATUS) rd_data = status;
    else if (cmd_addr < ADDR_STATUS) rd_data = regs_q[cmd_addr[2:0]];
  end

  // Byte presented on MISO at the start of each data byte
  always_comb begin
    out_byte = 8'h00;
    if (state_q == DATA) begin
      if (cmd_q[7:5] == OP_R_REGISTER && byte_cnt_q == 3'd1) out_byte = rd_data;
      else if (cmd_q == OP_R_RX_PAYLOAD && in_payload) out_byte = rx_buf_q[{data_idx, 3'b000} +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (csn_fall) state_d = CMD;
      CMD: begin
        if (last_bit) begin
          if (byte_in == OP_NOP) state_d = IGNORE;
          else if (byte_in[7:5] == OP_R_REGISTER || byte_in[7:5] == OP_W_REGISTER ||
                   byte_in == OP_R_RX_PAYLOAD || byte_in == OP_W_TX_PAYLOAD) state_d = DATA;
          else state_d = IGNORE;
        end
      end
      default: ;
    endcase
    if (csn_rise) state_d = IDLE;
  end

  always_ff @(posedge clk_10 or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk_10 or posedge rst) begin
    if (rst) begin
      mosi_sync_q <= 2'b00;
      sout_q      <= 8'h00;
      sin_q       <= 7'h00;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 3'd0;
      cmd_q       <= 8'h00;
      for (int i = 0; i < 7; i++) regs_q[i] <= reg_reset_value(3'(i));
      rx_dr_q     <= 1'b0;
      tx_ds_q     <= 1'b0;
      rx_buf_q    <= 32'h0;
      tx_buf_q    <= 32'h0;
      tx_out_q    <= 32'h0;
      tx_valid_q  <= 1'b0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      tx_valid_q  <= 1'b0;

      if (state_q == IDLE && csn_fall) begin
        sout_q     <= status;
        bit_cnt_q  <= 3'd0;
        byte_cnt_q <= 3'd0;
      end else if (active) begin
        if (sck_rise) begin
          sin_q     <= byte_in[6:0];
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7 && byte_cnt_q != 3'd7) byte_cnt_q <= byte_cnt_q + 3'd1;
        end
        // A fall with no bits pending opens a new byte
        if (sck_fall) sout_q <= (bit_cnt_q == 3'd0) ? out_byte : {sout_q[6:0], 1'b0};
      end

      if (state_q == CMD && last_bit) cmd_q <= byte_in;
      if (we && cmd_addr < ADDR_STATUS) regs_q[cmd_addr[2:0]] <= byte_in;

      if (rx_payload_load) rx_dr_q <= 1'b1;
      else if (rx_clear || (we && cmd_addr == ADDR_STATUS && byte_in[STATUS_RX_DR])) rx_dr_q <= 1'b0;

      if (tx_done_in) tx_ds_q <= 1'b1;
      else if (we && cmd_addr == ADDR_STATUS && byte_in[STATUS_TX_DS]) tx_ds_q <= 1'b0;

      if (rx_payload_load) rx_buf_q <= rx_payload_in;
      if (tx_fill) tx_buf_q[{data_idx, 3'b000} +: 8] <= byte_in;
      if (tx_commit) begin
        tx_out_q   <= tx_buf_q;
        tx_valid_q <= 1'b1;
      end
    end
  end

  assign miso             = active ? sout_q[7] : 1'b0;
  assign tx_payload_out   = tx_out_q;
  assign tx_payload_valid = tx_valid_q;
  assign config_out       = regs_q[ADDR_CONFIG[2:0]];

endmodule

// File: tb/tb_nrf_spi_responder.sv
// Bit-banged SPI master driving nrf_spi_responder; expected MISO bytes are queued
// alongside the MOSI bytes and compared as each byte completes.
module tb_nrf_spi_responder;

  localparam int HALF = 6;

  logic        clk_10 = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b0;
  logic        csn = 1'b1;
  logic        mosi = 1'b0;
  logic        miso;
  logic [31:0] rx_payload_in = 32'h0;
  logic        rx_payload_load = 1'b0;
  logic        tx_done_in = 1'b0;
  logic [31:0] tx_payload_out;
  logic        tx_payload_valid;
  logic [7:0]  config_out;

  int n_compared = 0;
  int n_mismatch = 0;
  int valid_cycles = 0;

  logic [7:0] mosi_q [$];
  logic [7:0] exp_q  [$];

  always #50 clk_10 = ~clk_10;

  nrf_spi_responder dut (
    .clk_10(clk_10), .rst(rst), .sck(sck), .csn(csn), .mosi(mosi), .miso(miso),
    .rx_payload_in(rx_payload_in), .rx_payload_load(rx_payload_load),
    .tx_done_in(tx_done_in), .tx_payload_out(tx_payload_out),
    .tx_payload_valid(tx_payload_valid), .config_out(config_out)
  );

  always @(posedge clk_10) if (tx_payload_valid) valid_cycles++;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_10);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic [7:0] e);
    mosi_q.push_back(b);
    exp_q.push_back(e);
  endtask

  // Shifts nbits MSB-first; with hook set, tx_done_in brackets the commit edge of the last bit
  task automatic spi_bits(input logic [7:0] tx, input int nbits, input bit hook,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      mosi = tx[i];
      wait_clks(HALF);
      rx[i] = miso;
      sck = 1'b1;
      if (hook && i == 0) begin
        wait_clks(2);
        tx_done_in = 1'b1;
        wait_clks(2);
        tx_done_in = 1'b0;
        wait_clks(HALF - 4);
      end else begin
        wait_clks(HALF);
      end
      sck = 1'b0;
    end
  endtask

  task automatic run_txn(input string tag, input bit hook);
    logic [7:0] b, r, e;
    int n;
    n = mosi_q.size();
    csn = 1'b0;
    wait_clks(8);
    for (int k = 0; k < n; k++) begin
      b = mosi_q.pop_front();
      spi_bits(b, 8, hook && (k == n - 1), r);
      e = exp_q.pop_front();
      check_val($sformatf("%s byte%0d", tag, k), {24'h0, r}, {24'h0, e});
    end
    wait_clks(HALF);
    csn = 1'b1;
    wait_clks(10);
    check_val({tag, " miso_idle"}, {31'h0, miso}, 32'h0);
    $display("txn %-12s %0d bytes", tag, n);
  endtask

  initial begin
    int v0;
    logic [7:0] r;

    repeat (3) @(posedge clk_10);
    #1;
    check_val("rst miso", {31'h0, miso}, 32'h0);
    check_val("rst config_out", {24'h0, config_out}, 32'h08);
    check_val("rst tx_valid", {31'h0, tx_payload_valid}, 32'h0);
    check_val("rst tx_out", tx_payload_out, 32'h0);
    rst = 1'b0;
    wait_clks(5);

    push(8'h05, 8'h0E); push(8'hFF, 8'h02); push(8'hFF, 8'h00);
    run_txn("rd_rf_ch", 1'b0);

    push(8'h20, 8'h0E); push(8'h0B, 8'h00);
    run_txn("wr_config", 1'b0);
    check_val("config_out", {24'h0, config_out}, 32'h0B);
    push(8'h00, 8'h0E); push(8'hFF, 8'h0B);
    run_txn("rd_config", 1'b0);

    push(8'h1F, 8'h0E); push(8'hFF, 8'h00);
    run_txn("rd_1f", 1'b0);

    push(8'h25, 8'h0E); push(8'h10, 8'h00); push(8'h20, 8'h00);
    run_txn("wr_rf_ch", 1'b0);
    push(8'h05, 8'h0E); push(8'hFF, 8'h10);
    run_txn("rd_rf_ch2", 1'b0);

    v0 = valid_cycles;
    push(8'hA0, 8'h0E); push(8'h11, 8'h00); push(8'h22, 8'h00);
    push(8'h33, 8'h00); push(8'h44, 8'h00);
    run_txn("w_tx4", 1'b0);
    check_val("tx_out 4B", tx_payload_out, 32'h44332211);
    check_val("tx_valid 4B", valid_cycles - v0, 32'd1);

    v0 = valid_cycles;
    push(8'hA0, 8'h0E); push(8'h55, 8'h00); push(8'h66, 8'h00); push(8'h77, 8'h00);
    run_txn("w_tx3", 1'b0);
    check_val("tx_out 3B", tx_payload_out, 32'h44332211);
    check_val("tx_valid 3B", valid_cycles - v0, 32'd0);

    rx_payload_in = 32'hDEADBEEF;
    rx_payload_load = 1'b1;
    wait_clks(1);
    rx_payload_load = 1'b0;
    push(8'hFF, 8'h40);
    run_txn("nop_rx_dr", 1'b0);
    push(8'h61, 8'h40); push(8'hFF, 8'hEF); push(8'hFF, 8'hBE);
    push(8'hFF, 8'hAD); push(8'hFF, 8'hDE);
    run_txn("r_rx", 1'b0);
    push(8'hFF, 8'h0E);
    run_txn("nop_rx_clr", 1'b0);

    tx_done_in = 1'b1;
    wait_clks(1);
    tx_done_in = 1'b0;
    push(8'hFF, 8'h2E);
    run_txn("nop_tx_ds", 1'b0);
    push(8'h27, 8'h2E); push(8'h20, 8'h00);
    run_txn("w1c_race", 1'b1);
    push(8'hFF, 8'h2E);
    run_txn("nop_race", 1'b0);
    push(8'h27, 8'h2E); push(8'h20, 8'h00);
    run_txn("w1c", 1'b0);
    push(8'hFF, 8'h0E);
    run_txn("nop_w1c", 1'b0);

    // RF_CH currently 0x10; reset lands mid data byte of a write to it
    csn = 1'b0;
    wait_clks(8);
    spi_bits(8'h25, 8, 1'b0, r);
    spi_bits(8'h07, 7, 1'b0, r);
    wait_clks(2);
    rst = 1'b1;
    #10;
    check_val("midrst miso", {31'h0, miso}, 32'h0);
    check_val("midrst config_out", {24'h0, config_out}, 32'h08);
    csn = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(5);
    $display("txn %-12s reset mid-byte", "midrst");
    push(8'h05, 8'h0E); push(8'hFF, 8'h02);
    run_txn("rd_after_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/nrf_spi_responder.md
# nrf_spi_responder

SPI-slave model of the nRF24L01 command interface: the responder end of the link driven by the on-board SPI controller's transmit and receive paths. It runs on the 10 MHz controller clock. It oversamples SCK/CSN/MOSI, decodes nRF24L01 commands, serves a small register file plus 4-byte RX/TX payload buffers, and drives MISO. It is used as a loop-back target on the DE10-Lite and as the device model in controller benches.

## Interface
- No parameters; payload width (4 bytes) and register map are fixed constants in the package.
- clk_10  in  1  10 MHz system clock; all logic on rising edge.
- rst  in  1  Asynchronous, active-high reset.
- sck  in  1  SPI clock from master, mode 0, asynchronous to clk_10.
- csn  in  1  Chip select, active low.
- mosi  in  1  Master-out data, MSB first.
- miso  out  1  Slave-out data; 0 while csn high.
- rx_payload_in  in  32  Payload presented to master by R_RX_PAYLOAD; byte 0 = [7:0].
- rx_payload_load  in  1  1-cycle pulse: capture rx_payload_in, set STATUS.RX_DR.
- tx_done_in  in  1  1-cycle pulse: set STATUS.TX_DS.
- tx_payload_out  out  32  Last complete W_TX_PAYLOAD; byte 0 = [7:0].
- tx_payload_valid  out  1  1-cycle pulse when tx_payload_out updates.
- config_out  out  8  Current CONFIG register (addr 0x00).

## Operation
- Input conditioning: sck, csn, mosi each 2-FF synchronized; rise/fall of sck and csn detected on the synchronized signals.
- Registers: 0x00 CONFIG=0x08, 0x01 EN_AA=0x3F, 0x02 EN_RXADDR=0x03, 0x03 SETUP_AW=0x03, 0x04 SETUP_RETR=0x03, 0x05 RF_CH=0x02, 0x06 RF_SETUP=0x0F, 0x07 STATUS.
- STATUS = {0, RX_DR, TX_DS, 0, RX_P_NO[2:0], 0}; RX_P_NO = 000 when RX_DR=1, else 111. Reset: RX_DR=TX_DS=0, read value 0x0E.
- Addresses 0x08–0x1F read 0x00; writes to them are ignored.
- Commands: R_REGISTER 000AAAAA, W_REGISTER 001AAAAA, R_RX_PAYLOAD 0x61, W_TX_PAYLOAD 0xA0, NOP 0xFF. Any other opcode goes to IGNORE.
- FSM states:
  - IDLE: csn high, miso=0. A csn fall loads the shift-out register with STATUS and goes to CMD.
  - CMD: 8 sck rises shift in the opcode while STATUS shifts out. On the 8th rise, decode and go to DATA or IGNORE; NOP goes to IGNORE.
  - DATA: per byte, load the out-byte at byte start.
    - R_REGISTER: register value on byte 1; 0x00 afterwards.
    - R_RX_PAYLOAD: payload bytes 0..3, then 0x00.
    - Writes: out-byte 0x00.
  - IGNORE: shifts out 0x00; nothing is committed.
- W_REGISTER commits on the 8th sck rise of data byte 1; later bytes are ignored.
  - STATUS writes are write-1-to-clear on bits 6:5.
  - The RX_P_NO and read-only bits are unaffected.
- W_TX_PAYLOAD: data bytes 1..4 fill tx_buf[7:0]..[31:24]. On csn rise with ≥4 complete data bytes, copy to tx_payload_out and pulse tx_payload_valid. With fewer bytes, the payload is discarded.
- R_RX_PAYLOAD: on csn rise with ≥4 complete data bytes shifted, clear RX_DR.
- csn rise in any state returns to IDLE; a partial byte is discarded and not committed.
- Simultaneous events:
  - rx_payload_load and the RX_DR clear in the same cycle: set wins (RX_DR=1).
  - tx_done_in and a W1C write to TX_DS in the same cycle: set wins.
  - rx_payload_load during an active R_RX_PAYLOAD: buffer updates, and bytes not yet loaded come from the new value.
- Reset (any time, including mid-transaction): all registers to reset values, FSM to IDLE, miso=0, tx_payload_out=0, tx_payload_valid=0, config_out=0x08.

## Timing
- Synchronizer plus edge detect: an sck/csn edge is acted on 3 clk_10 cycles after the pin edge.
- Constraints on the master:
  - sck high and low each ≥ 4 clk_10 periods (sck ≤ 1.25 MHz).
  - csn fall to first sck rise ≥ 5 clk_10 periods.
  - Last sck fall to csn rise ≥ 4 clk_10 periods.
- MOSI is sampled at the detected sck rise, from the synchronized mosi.
- MISO:
  - Changes at the detected sck fall.
  - First bit (STATUS[7]) is valid ≤4 cycles after the csn fall.
  - Returns to 0 ≤4 cycles after the csn rise.
- Commit timing:
  - W_REGISTER: takes effect on the cycle after the detected 8th rise.
  - tx_payload_valid: asserted for exactly 1 cycle, on the cycle after the detected csn rise.
  - config_out: updates in the same cycle as the register.

## Structure
- Package nrf_spi_pkg holds:
  - opcode constants;
  - register address constants and reset values;
  - STATUS bit indices;
  - the FSM state enum (IDLE, CMD, DATA, IGNORE);
  - PAYLOAD_BYTES=4.
- Sub-module spi_sync_edge: 2-FF synchronizer plus registered rise/fall pulses. It is instantiated for sck and csn; mosi uses the synchronizer output only.

## Test plan
- Reset, then R_REGISTER 0x05 (bytes 0x05, 0xFF) -> MISO bytes 0x0E, 0x02.
- W_REGISTER 0x00 with data 0x0B, csn high, then R_REGISTER 0x00 -> config_out=0x0B; read returns 0x0B.
- W_TX_PAYLOAD 0xA0 then 0x11,0x22,0x33,0x44 -> tx_payload_out=0x44332211 and one tx_payload_valid pulse. Repeat with 3 bytes -> no pulse, output unchanged.
- rx_payload_load with 0xDEADBEEF, then NOP -> STATUS 0x40. Then R_RX_PAYLOAD -> MISO 0x40, 0xEF,0xBE,0xAD,0xDE; the next NOP returns 0x0E.
- tx_done_in -> STATUS 0x2E. Then W_REGISTER 0x07 with 0x20 issued in the same cycle as a second tx_done_in -> TX_DS remains 1.
- rst asserted mid-byte during W_REGISTER 0x05 -> RF_CH reads 0x02, miso=0, FSM IDLE; the next transaction behaves normally.
